// File: rtl/gate_share_arbiter_if.sv
// rtl/gate_share_arbiter_if.sv - requester/gate bundle for gate_share_arbiter
// chk_err exists only when GATE_CHECK_EN is defined.
interface gate_share_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      res_out;
  logic [WIDTH-1:0]      gate_a;
  logic [WIDTH-1:0]      gate_b;
  logic [WIDTH-1:0]      gate_y;
  logic                  busy;
`ifdef GATE_CHECK_EN
  logic                  chk_err;
`endif

  modport master (
    output req, a_in, b_in, gate_y,
    input  gnt, done, res_out, gate_a, gate_b, busy
`ifdef GATE_CHECK_EN
    , input chk_err
`endif
  );

  modport slave (
    input  req, a_in, b_in, gate_y,
    output gnt, done, res_out, gate_a, gate_b, busy
`ifdef GATE_CHECK_EN
    , output chk_err
`endif
  );
endinterface

// File: rtl/gate_share_arbiter.sv
// rtl/gate_share_arbiter.sv - round-robin sharing of one external AND gate among NREQ requesters
// Optional GATE_CHECK_EN adds a sticky chk_err when gate_y != gate_a & gate_b.
module gate_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  gate_share_arbiter_if.slave bus
);
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDXW-1:0] LAST_INIT = IDXW'(NREQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  state_t           r_state, w_state;
  logic [IDXW-1:0]  r_last, w_last;
  logic [IDXW-1:0]  r_idx, w_idx;
  logic [IDXW-1:0]  w_pick, w_cand;
  logic             w_found;
  logic [NREQ-1:0]  r_gnt, w_gnt;
  logic [NREQ-1:0]  r_done, w_done;
  logic [WIDTH-1:0] r_res, w_res;
  logic [WIDTH-1:0] r_gate_a, w_gate_a;
  logic [WIDTH-1:0] r_gate_b, w_gate_b;
`ifdef GATE_CHECK_EN
  logic             r_chk, w_chk;
`endif

  // Search starts just after the last served requester so every active one is reached within NREQ grants.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last;
    w_cand  = r_last;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand = IDXW'((int'(r_last) + k) % NREQ);
      if (!w_found && bus.req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_comb begin
    w_state  = r_state;
    w_last   = r_last;
    w_idx    = r_idx;
    w_gnt    = r_gnt;
    w_done   = r_done;
    w_res    = r_res;
    w_gate_a = r_gate_a;
    w_gate_b = r_gate_b;
`ifdef GATE_CHECK_EN
    w_chk    = r_chk;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state = S_ISSUE;
          w_idx   = w_pick;
          w_gnt   = NREQ'(1) << w_pick;
          for (int i = 0; i < NREQ; i++) begin
            if (w_pick == IDXW'(i)) begin
              w_gate_a = bus.a_in[i*WIDTH +: WIDTH];
              w_gate_b = bus.b_in[i*WIDTH +: WIDTH];
            end
          end
        end
      end
      S_ISSUE: begin
        // Operands were latched last edge, so gate_y has settled and is captured now.
        w_state = S_DONE;
        w_res   = bus.gate_y;
        w_done  = NREQ'(1) << r_idx;
        w_gnt   = '0;
        w_last  = r_idx;
`ifdef GATE_CHECK_EN
        if (bus.gate_y != (r_gate_a & r_gate_b)) w_chk = 1'b1;
`endif
      end
      S_DONE: begin
        w_state = S_IDLE;
        w_done  = '0;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_last   <= LAST_INIT;
      r_idx    <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_res    <= '0;
      r_gate_a <= '0;
      r_gate_b <= '0;
`ifdef GATE_CHECK_EN
      r_chk    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state;
      r_last   <= w_last;
      r_idx    <= w_idx;
      r_gnt    <= w_gnt;
      r_done   <= w_done;
      r_res    <= w_res;
      r_gate_a <= w_gate_a;
      r_gate_b <= w_gate_b;
`ifdef GATE_CHECK_EN
      r_chk    <= w_chk;
`endif
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.done    = r_done;
  assign bus.res_out = r_res;
  assign bus.gate_a  = r_gate_a;
  assign bus.gate_b  = r_gate_b;
  assign bus.busy    = (r_state != S_IDLE);
`ifdef GATE_CHECK_EN
  assign bus.chk_err = r_chk;
`endif
endmodule

// File: tb/tb_gate_share_arbiter.sv
// tb/tb_gate_share_arbiter.sv - self-checking bench for gate_share_arbiter
// Transaction-timeline model plus directed literal expectations.
module tb_gate_share_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gate_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  gate_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  logic             r_force = 1'b0;
  logic [WIDTH-1:0] r_force_val = '0;
  assign bus.gate_y = r_force ? r_force_val : (bus.gate_a & bus.gate_b);

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
  endtask

  // Model: an operation granted at edge E0 is "age 0" after E0, done at age 1, idle at age 2; free again at E3.
  bit               m_act;
  int               m_age, m_owner, m_last;
  logic [WIDTH-1:0] m_ga, m_gb, m_res, m_opres;
  bit               m_opbad, m_chk;

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    int j;
    for (int k = 0; k < NREQ; k++) begin
      j = (last + 1 + k) % NREQ;
      if (r[j]) return j;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_age = 0; m_owner = 0; m_last = NREQ - 1;
      m_ga = '0; m_gb = '0; m_res = '0; m_opres = '0; m_opbad = 0; m_chk = 0;
    end else if (m_act && m_age < 2) begin
      m_age++;
      if (m_age == 1) begin
        m_res  = m_opres;
        m_last = m_owner;
        if (m_opbad) m_chk = 1;
      end
    end else begin
      m_act = 0;
      if (bus.req != '0) begin
        m_owner = rr_pick(bus.req, m_last);
        m_ga    = bus.a_in[m_owner*WIDTH +: WIDTH];
        m_gb    = bus.b_in[m_owner*WIDTH +: WIDTH];
        m_opres = r_force ? r_force_val : (m_ga & m_gb);
        m_opbad = r_force && (r_force_val != (m_ga & m_gb));
        m_act   = 1;
        m_age   = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("gnt", 32'(bus.gnt), (m_act && m_age == 0) ? (32'd1 << m_owner) : 32'd0);
    chk("done", 32'(bus.done), (m_act && m_age == 1) ? (32'd1 << m_owner) : 32'd0);
    chk("busy", 32'(bus.busy), 32'(m_act && m_age <= 1));
    chk("res_out", 32'(bus.res_out), 32'(m_res));
    chk("gate_a", 32'(bus.gate_a), 32'(m_ga));
    chk("gate_b", 32'(bus.gate_b), 32'(m_gb));
`ifdef GATE_CHECK_EN
    chk("chk_err", 32'(bus.chk_err), 32'(m_chk));
`endif
  end

  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.a_in[i*WIDTH +: WIDTH] = a;
    bus.b_in[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(output int idx, output logic [WIDTH-1:0] res, output int when);
    idx = -1; res = '0; when = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (bus.done != '0) begin
        for (int i = 0; i < NREQ; i++) if (bus.done[i]) idx = i;
        res  = bus.res_out;
        when = cyc;
        bus.req[idx] = 1'b0;
        return;
      end
    end
    chk("done_timeout", 1, 0);
  endtask

  task automatic wait_gnt();
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (bus.gnt != '0) return;
    end
    chk("gnt_timeout", 1, 0);
  endtask

  int               idx, w, prev;
  logic [WIDTH-1:0] res;

  initial begin
    bus.req = '0; bus.a_in = '0; bus.b_in = '0;
    do_reset();

    set_op(2, 8'hF0, 8'h3C);
    bus.req = 4'b0100;
    wait_done(idx, res, w);
    chk("single_idx", 32'(idx), 2);
    chk("single_res", 32'(res), 32'h30);

    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 8'hFF, 8'hFF);
    bus.req = 4'b1111;
    prev = 0;
    for (int n = 0; n < NREQ; n++) begin
      wait_done(idx, res, w);
      chk("all_order", 32'(idx), 32'(n));
      chk("all_res", 32'(res), 32'hFF);
      if (n > 0) chk("all_spacing", 32'(w - prev), 3);
      prev = w;
    end

    set_op(0, 8'h3C, 8'h0F); set_op(1, 8'hC3, 8'hF0);
    set_op(2, 8'h00, 8'h00); set_op(3, 8'h5A, 8'hFF);
    bus.req = 4'b0010;
    wait_done(idx, res, w);
    chk("rr_a_idx", 32'(idx), 1); chk("rr_a_res", 32'(res), 32'hC0);
    bus.req = 4'b0011;
    wait_done(idx, res, w);
    chk("rr_b_idx", 32'(idx), 0); chk("rr_b_res", 32'(res), 32'h0C);
    wait_done(idx, res, w);
    chk("rr_c_idx", 32'(idx), 1);
    bus.req = 4'b1010;
    wait_done(idx, res, w);
    chk("rr_d_idx", 32'(idx), 3); chk("rr_d_res", 32'(res), 32'h5A);
    wait_done(idx, res, w);
    chk("rr_e_idx", 32'(idx), 1);

    set_op(0, 8'h96, 8'h3C);
    bus.req = 4'b0001;
    wait_gnt();
    bus.req = '0;
    wait_done(idx, res, w);
    chk("wd_idx", 32'(idx), 0); chk("wd_res", 32'(res), 32'h14);
    repeat (3) begin
      @(negedge clk);
      chk("wd_nognt", 32'(bus.gnt), 0);
    end

    set_op(3, 8'hE7, 8'h7E);
    bus.req = 4'b1000;
    wait_gnt();
    #2 rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(bus.gnt), 0);
    chk("async_done", 32'(bus.done), 0);
    chk("async_res", 32'(bus.res_out), 0);
    chk("async_ga", 32'(bus.gate_a), 0);
    chk("async_gb", 32'(bus.gate_b), 0);
    chk("async_busy", 32'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(idx, res, w);
    chk("post_rst_idx", 32'(idx), 3); chk("post_rst_res", 32'(res), 32'h66);

`ifdef GATE_CHECK_EN
    do_reset();
    set_op(0, 8'h00, 8'h00);
    r_force = 1'b1; r_force_val = 8'h01;
    bus.req = 4'b0001;
    wait_done(idx, res, w);
    chk("gc_res", 32'(res), 32'h01);
    chk("gc_err", 32'(bus.chk_err), 1);
    r_force = 1'b0;
    set_op(0, 8'hFF, 8'hFF);
    bus.req = 4'b0001;
    wait_done(idx, res, w);
    chk("gc_res2", 32'(res), 32'hFF);
    chk("gc_sticky", 32'(bus.chk_err), 1);
    do_reset();
    chk("gc_cleared", 32'(bus.chk_err), 0);
`endif

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/gate_share_arbiter.md
Name: gate_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one external 2-input bitwise AND gate unit among NREQ requesters.
- Latches the winning requester's operands onto the gate inputs, captures the gate output one cycle later and returns it with a one-cycle done pulse.
- Sits between the gate instance and the blocks that want its result.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  request per requester; level, held until done.
- a_in  input  NREQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- b_in  input  NREQ*WIDTH  operand B, same packing.
- gnt  output  NREQ  one-hot grant, registered.
- done  output  NREQ  one-hot one-cycle completion pulse, registered.
- res_out  output  WIDTH  captured result, registered, valid while done is high and held afterwards.
- gate_a  output  WIDTH  operand A to the shared gate, registered.
- gate_b  output  WIDTH  operand B to the shared gate, registered.
- gate_y  input  WIDTH  result from the shared gate; combinational from gate_a/gate_b.
- busy  output  1  high in ISSUE and DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: gnt=0, done=0, res_out=0, gate_a=0, gate_b=0, busy=0, state=IDLE, last pointer=NREQ-1, so requester 0 has first priority.
- IDLE state:
  - If req==0, stay in IDLE.
  - Otherwise select the first set req bit searching from (last+1) mod NREQ upward with wrap.
  - At the edge: gnt<=onehot(idx), gate_a/gate_b<=that requester's operands, idx stored, state->ISSUE.
- ISSUE state (1 cycle):
  - gate_y is sampled at the edge.
  - res_out<=gate_y, done<=onehot(idx), gnt<=0, last<=idx, state->DONE.
- DONE state (1 cycle):
  - done<=0, state->IDLE.
  - No arbitration occurs in DONE.
- Timing:
  - req sampled at edge E0 gives gnt high after E0, done and res_out after E1, back to IDLE after E2.
  - Next grant can appear after E3, so the minimum service interval is 3 cycles per operation.
- Requester obligations:
  - Keep req and operands stable until done.
  - Drop req in the cycle done is seen. req still high at the next IDLE edge is a new request, arbitrated round-robin.
- req withdrawn during ISSUE: the operation completes normally and done still pulses, because the operands are already latched.
- Requests arriving during ISSUE/DONE wait; they are never lost while req is held.
- Simultaneous requests: exactly one grant. A requester that stays active is served within NREQ operations (no starvation).
- Pointer wrap: last=NREQ-1 searches from 0; indices wrap modulo NREQ.
- Reset mid-operation: all outputs return to reset values immediately, the in-flight operation is discarded with no done pulse, and the pointer is restored to NREQ-1.
- gnt and done are never both high. At most one bit of each is set.

Optional Feature:
- Macro: GATE_CHECK_EN.
- Defined:
  - Adds output chk_err (1 bit, reset 0).
  - In ISSUE, compares gate_y against gate_a & gate_b.
  - On mismatch, chk_err<=1 (sticky until reset). Operation still completes and returns gate_y unchanged.
- Undefined: no chk_err port and no comparator; all other behaviour identical.

Test Plan:
- Single request: req=4'b0100, a2=8'hF0, b2=8'h3C -> gnt=4'b0100 one cycle after sampling, then done=4'b0100 for exactly one cycle with res_out=8'h30; busy high for 2 cycles.
- All four requesting from reset, held until each done, with ai=bi=8'hFF -> grants in order 0,1,2,3, spaced 3 cycles; each done pulse carries res_out=8'hFF.
- Round-robin fairness: serve req1; then req0 and req1 both held -> 0 is served next, then 1. Then req1 and req3 -> 3 is served before 1.
- Withdraw during ISSUE: req=4'b0001, drop req in ISSUE -> done=4'b0001 still pulses with correct result; next cycle IDLE with no grant.
- Reset mid-op: assert rst_n=0 during ISSUE -> gnt, done, res_out, gate_a, gate_b and busy go to 0 asynchronously. After release with req=4'b1000, requester 3 is granted and completes normally.
- GATE_CHECK_EN: force gate_y=8'h01 while gate_a=gate_b=8'h00 -> chk_err=1 after the ISSUE edge and stays high. A later correct operation leaves it high until rst_n low.
